// File: rtl/audio_stream_router.sv
// audio_stream_router
//   Sample path from a capture front end (one in_wr strobe per sample) to an
//   I2S transmitter (one out_rd strobe per frame). A small FIFO decouples the
//   two rates. Input samples are converted to signed and MSB-aligned to
//   OUT_W, then amplified by a per-read left shift with saturation. The result
//   is routed to the left and/or right channel by mode.
//
//   Optional build macro: LEVEL_METER_EN
//     defined   : led is a peak-hold level bar with 6 dB steps, driven by popped samples
//     undefined : led shows the top 8 bits of in_data, latched on every in_wr
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   in_data    in   IN_W   capture sample (offset-binary or two's complement)
//   in_wr      in   push strobe
//   out_rd     in   pop strobe
//   out_l      out  OUT_W  left sample, signed, registered
//   out_r      out  OUT_W  right sample, signed, registered
//   mode       in   2      00 both, 01 left only, 10 right only, 11 mute
//   gain       in   4      left-shift amount 0..15
//   clr_flags  in   clears overrun/underrun (a coincident set wins)
//   overrun    out  sticky: write dropped, FIFO full
//   underrun   out  sticky: read while FIFO empty
//   fill       out  FIFO occupancy 0..DEPTH
//   led        out  8      level display
module audio_stream_router #(
  parameter int IN_W      = 12,
  parameter int OUT_W     = 24,
  parameter int DEPTH     = 16,
  parameter int IN_SIGNED = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IN_W-1:0]          in_data,
  input  logic                     in_wr,
  input  logic                     out_rd,
  output logic [OUT_W-1:0]         out_l,
  output logic [OUT_W-1:0]         out_r,
  input  logic [1:0]               mode,
  input  logic [3:0]               gain,
  input  logic                     clr_flags,
  output logic                     overrun,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   fill,
  output logic [7:0]               led
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = PTR_W + 1;
  localparam int PAD    = OUT_W - IN_W;
  // 16 spare bits leave room for a shift of up to 15 without losing the sign
  localparam int WIDE_W = OUT_W + 16;

  localparam logic [FILL_W-1:0] FULL = FILL_W'(DEPTH);

  localparam logic signed [WIDE_W-1:0] SAT_HI = (WIDE_W'(1) <<< (OUT_W - 1)) - WIDE_W'(1);
  localparam logic signed [WIDE_W-1:0] SAT_LO = -(WIDE_W'(1) <<< (OUT_W - 1));

  typedef enum logic [1:0] {
    ROUTE_BOTH  = 2'b00,
    ROUTE_LEFT  = 2'b01,
    ROUTE_RIGHT = 2'b10,
    ROUTE_MUTE  = 2'b11
  } route_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [IN_W-1:0]         mem_q [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0]       fill_q, fill_d;
  logic signed [OUT_W-1:0] out_l_q, out_l_d;
  logic signed [OUT_W-1:0] out_r_q, out_r_d;
  logic                    overrun_q, overrun_d;
  logic                    underrun_q, underrun_d;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic rd_ok;
  logic wr_ok;
  logic [IN_W-1:0] s_in;

  always_comb begin
    rd_ok = out_rd && (fill_q != '0);
    // A write at full still succeeds when a read frees a slot in the same cycle.
    wr_ok = in_wr && ((fill_q != FULL) || rd_ok);
  end

  // Offset-binary input becomes two's complement by flipping the MSB.
  always_comb begin
    if (IN_SIGNED != 0) begin
      s_in = in_data;
    end else begin
      s_in = {~in_data[IN_W-1], in_data[IN_W-2:0]};
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers and occupancy
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({wr_ok, rd_ok})
      2'b10:   fill_d = fill_q + FILL_W'(1);
      2'b01:   fill_d = fill_q - FILL_W'(1);
      default: fill_d = fill_q;
    endcase
  end

  // Storage carries no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= s_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path: align, gain, saturate, route
  // ---------------------------------------------------------------------------
  logic signed [IN_W-1:0]   s_rd;
  logic signed [OUT_W-1:0]  x_al;
  logic signed [WIDE_W-1:0] x_wide;
  logic signed [WIDE_W-1:0] x_gain;
  logic signed [OUT_W-1:0]  y;

  always_comb begin
    s_rd   = mem_q[rd_ptr_q];
    x_al   = OUT_W'(s_rd) <<< PAD;
    x_wide = WIDE_W'(x_al);
    x_gain = x_wide <<< gain;
    if (x_gain > SAT_HI) begin
      y = SAT_HI[OUT_W-1:0];
    end else if (x_gain < SAT_LO) begin
      y = SAT_LO[OUT_W-1:0];
    end else begin
      y = x_gain[OUT_W-1:0];
    end
  end

  always_comb begin
    out_l_d = out_l_q;
    out_r_d = out_r_q;
    if (rd_ok) begin
      case (route_e'(mode))
        ROUTE_BOTH: begin
          out_l_d = y;
          out_r_d = y;
        end
        ROUTE_LEFT: begin
          out_l_d = y;
          out_r_d = '0;
        end
        ROUTE_RIGHT: begin
          out_l_d = '0;
          out_r_d = y;
        end
        default: begin
          out_l_d = '0;
          out_r_d = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky flags: a set in the same cycle as clr_flags wins
  // ---------------------------------------------------------------------------
  always_comb begin
    overrun_d  = overrun_q;
    underrun_d = underrun_q;
    if (clr_flags) begin
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
    end
    if (in_wr && !wr_ok) begin
      overrun_d = 1'b1;
    end
    if (out_rd && !rd_ok) begin
      underrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      out_l_q    <= '0;
      out_r_q    <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      out_l_q    <= out_l_d;
      out_r_q    <= out_r_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Level display
  // ---------------------------------------------------------------------------
`ifdef LEVEL_METER_EN
  // The popped sample is captured and metered one cycle later, which keeps
  // the magnitude/compare chain out of the FIFO read path. Metering ignores
  // mode, so muted audio is still shown.
  logic [IN_W-1:0] last_s_q, last_s_d;
  logic            last_vld_q, last_vld_d;
  logic [IN_W-2:0] peak_q, peak_d;
  logic [IN_W-1:0] neg_s;
  logic [IN_W-2:0] mag;
  logic [7:0]      led_m;

  always_comb begin
    last_s_d   = rd_ok ? s_rd : last_s_q;
    last_vld_d = rd_ok;
  end

  always_comb begin
    neg_s = -last_s_q;
    if (last_s_q == {1'b1, {(IN_W-1){1'b0}}}) begin
      mag = '1;
    end else if (last_s_q[IN_W-1]) begin
      mag = neg_s[IN_W-2:0];
    end else begin
      mag = last_s_q[IN_W-2:0];
    end
  end

  always_comb begin
    peak_d = peak_q;
    if (last_vld_q) begin
      if (mag > peak_q) begin
        peak_d = mag;
      end else if (peak_q != '0) begin
        peak_d = peak_q - (IN_W-1)'(1);
      end
    end
  end

  always_comb begin
    led_m = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      led_m[i] = (32'(peak_q) >= (32'd1 << (IN_W - 9 + i)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_s_q   <= '0;
      last_vld_q <= 1'b0;
      peak_q     <= '0;
    end else begin
      last_s_q   <= last_s_d;
      last_vld_q <= last_vld_d;
      peak_q     <= peak_d;
    end
  end

  assign led = led_m;
`else
  logic [7:0] led_q, led_d;

  // Latched on every strobe, including writes dropped at full.
  always_comb begin
    led_d = in_wr ? in_data[IN_W-1 -: 8] : led_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q <= '0;
    end else begin
      led_q <= led_d;
    end
  end

  assign led = led_q;
`endif

  assign out_l    = out_l_q;
  assign out_r    = out_r_q;
  assign overrun  = overrun_q;
  assign underrun = underrun_q;
  assign fill     = fill_q;

endmodule

// File: tb/tb_audio_stream_router.sv
module tb_audio_stream_router;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] in_data;
  logic        in_wr;
  logic        out_rd;
  logic [23:0] out_l;
  logic [23:0] out_r;
  logic [1:0]  mode;
  logic [3:0]  gain;
  logic        clr_flags;
  logic        overrun;
  logic        underrun;
  logic [4:0]  fill;
  logic [7:0]  led;

  int n_checks = 0;
  int n_fail   = 0;

  audio_stream_router #(
    .IN_W(12),
    .OUT_W(24),
    .DEPTH(16),
    .IN_SIGNED(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_wr(in_wr),
    .out_rd(out_rd),
    .out_l(out_l),
    .out_r(out_r),
    .mode(mode),
    .gain(gain),
    .clr_flags(clr_flags),
    .overrun(overrun),
    .underrun(underrun),
    .fill(fill),
    .led(led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [11:0] v);
    in_data = v;
    in_wr   = 1'b1;
    tick();
    in_wr   = 1'b0;
  endtask

  task automatic pop();
    out_rd = 1'b1;
    tick();
    out_rd = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // gain 0, offset-binary input: flip MSB and MSB-align into 24 bits
  function automatic logic [23:0] conv0(input logic [11:0] v);
    conv0 = {~v[11], v[10:0], 12'h000};
  endfunction

  initial begin
    rst = 1'b1; in_data = '0; in_wr = 1'b0; out_rd = 1'b0;
    mode = 2'b00; gain = 4'd0; clr_flags = 1'b0;
    do_reset();

    // reset state
    check("rst_fill", 32'(fill), 32'd0);
    check("rst_l", 32'(out_l), 32'h0);
    check("rst_r", 32'(out_r), 32'h0);
    check("rst_ovr", 32'(overrun), 32'd0);
    check("rst_udr", 32'(underrun), 32'd0);
    check("rst_led", 32'(led), 32'h0);

    // 1. conversion
    push(12'h800);
    push(12'hFFF);
`ifndef LEVEL_METER_EN
    check("led_fff", 32'(led), 32'hFF);
`endif
    push(12'h000);
`ifndef LEVEL_METER_EN
    check("led_000", 32'(led), 32'h00);
`endif
    check("conv_fill", 32'(fill), 32'd3);
    pop();
    check("conv_800_l", 32'(out_l), 32'h000000);
    check("conv_800_r", 32'(out_r), 32'h000000);
    pop();
    check("conv_fff_l", 32'(out_l), 32'h7FF000);
    check("conv_fff_r", 32'(out_r), 32'h7FF000);
    pop();
    check("conv_000_l", 32'(out_l), 32'h800000);
    check("conv_000_r", 32'(out_r), 32'h800000);

    // 2. gain = 4
    gain = 4'd4;
    push(12'hC00);
    push(12'h810);
    push(12'h000);
    pop();
    check("gain_sat_hi", 32'(out_l), 32'h7FFFFF);
    pop();
    check("gain_810", 32'(out_l), 32'h100000);
    check("gain_810_r", 32'(out_r), 32'h100000);
    pop();
    check("gain_sat_lo", 32'(out_l), 32'h800000);
    gain = 4'd0;

    // 3. full FIFO: 17 writes, 17th dropped
    for (int k = 1; k <= 17; k++) push(12'(k * 16));
    check("full_fill", 32'(fill), 32'd16);
    check("full_ovr", 32'(overrun), 32'd1);
`ifndef LEVEL_METER_EN
    check("full_led_dropped", 32'(led), 32'h11);
`endif
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("full_ovr_clr", 32'(overrun), 32'd0);
    // write + read at full
    in_data = 12'h120; in_wr = 1'b1; out_rd = 1'b1;
    tick();
    in_wr = 1'b0; out_rd = 1'b0;
    check("full_wr_rd_fill", 32'(fill), 32'd16);
    check("full_wr_rd_ovr", 32'(overrun), 32'd0);
    check("full_wr_rd_data", 32'(out_l), 32'(conv0(12'h010)));
    for (int k = 2; k <= 16; k++) begin
      pop();
      check($sformatf("full_pop%0d", k), 32'(out_l), 32'(conv0(12'(k * 16))));
    end
    pop();
    check("full_pop_last", 32'(out_l), 32'(conv0(12'h120)));
    check("full_empty_fill", 32'(fill), 32'd0);

    // 4. empty FIFO
    push(12'hA00);
    pop();
    check("emp_first", 32'(out_l), 32'h200000);
    pop();
    check("emp_hold_l", 32'(out_l), 32'h200000);
    check("emp_hold_r", 32'(out_r), 32'h200000);
    check("emp_udr", 32'(underrun), 32'd1);
    clr_flags = 1'b1; out_rd = 1'b1;
    tick();
    clr_flags = 1'b0; out_rd = 1'b0;
    check("emp_set_wins", 32'(underrun), 32'd1);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("emp_clr", 32'(underrun), 32'd0);
    // write + read while empty: no fall-through
    in_data = 12'h900; in_wr = 1'b1; out_rd = 1'b1;
    tick();
    in_wr = 1'b0; out_rd = 1'b0;
    check("emp_wr_rd_fill", 32'(fill), 32'd1);
    check("emp_wr_rd_udr", 32'(underrun), 32'd1);
    check("emp_wr_rd_hold", 32'(out_l), 32'h200000);
    pop();
    check("emp_wr_rd_pop", 32'(out_l), 32'h100000);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;

    // 5. modes
    mode = 2'b01;
    push(12'hA00);
    pop();
    check("m01_l", 32'(out_l), 32'h200000);
    check("m01_r", 32'(out_r), 32'h000000);
    mode = 2'b00;
    tick();
    check("m_hold_l", 32'(out_l), 32'h200000);
    check("m_hold_r", 32'(out_r), 32'h000000);
    mode = 2'b10;
    push(12'hA00);
    pop();
    check("m10_l", 32'(out_l), 32'h000000);
    check("m10_r", 32'(out_r), 32'h200000);
    mode = 2'b11;
    push(12'hA00);
    check("m11_fill_pre", 32'(fill), 32'd1);
    pop();
    check("m11_fill_post", 32'(fill), 32'd0);
    check("m11_l", 32'(out_l), 32'h000000);
    check("m11_r", 32'(out_r), 32'h000000);
    mode = 2'b00;

    // reset mid-stream discards contents
    push(12'h100);
    push(12'h200);
    push(12'h300);
    do_reset();
    check("mid_rst_fill", 32'(fill), 32'd0);
    check("mid_rst_l", 32'(out_l), 32'h0);
    push(12'h900);
    pop();
    check("mid_rst_first", 32'(out_l), 32'h100000);

`ifdef LEVEL_METER_EN
    // 6. level meter
    do_reset();
    push(12'hFFF);
    pop();
    tick();
    check("lvl_full", 32'(led), 32'hFF);
    push(12'h800);
    for (int k = 1; k <= 2047; k++) begin
      in_data = 12'h800; in_wr = 1'b1; out_rd = 1'b1;
      tick();
      in_wr = 1'b0; out_rd = 1'b0;
      tick();
      if (k == 1023) check("lvl_1023", 32'(led[7]), 32'd1);
      if (k == 1024) check("lvl_1024", 32'(led[7]), 32'd0);
      if (k == 2039) check("lvl_2039", 32'(led), 32'h01);
      if (k == 2047) check("lvl_2047", 32'(led), 32'h00);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_stream_router.md
Name: audio_stream_router

Overview:
- Parametrised sample path between an audio capture front end (SPI ADC, strobe per sample) and an I2S transmitter (strobe per frame).
- Decouples the two rates with a small FIFO.
- Converts offset-binary or signed input to MSB-aligned signed output of any width.
- Applies per-read gain with saturation, routes to L/R by mode, and flags overruns and underruns.

Parameters:
- IN_W, 12: input sample width; IN_W >= 9.
- OUT_W, 24: output sample width; OUT_W >= IN_W.
- DEPTH, 16: FIFO depth in samples; power of 2, >= 2.
- IN_SIGNED, 0: 0 = input is unsigned offset-binary (converted by inverting MSB); 1 = input is two's complement.

Ports:
- clk  in  1  system clock. Single clock; reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset.
- in_data  in  IN_W  capture sample.
- in_wr  in  1  one-cycle strobe: push in_data.
- out_rd  in  1  one-cycle strobe from transmitter: pop next sample.
- out_l  out  OUT_W  left sample, signed, registered.
- out_r  out  OUT_W  right sample, signed, registered.
- mode  in  2  00 both channels, 01 left only, 10 right only, 11 mute.
- gain  in  4  left-shift amount 0..15.
- clr_flags  in  1  clears overrun and underrun.
- overrun  out  1  sticky: write dropped because FIFO full.
- underrun  out  1  sticky: read while FIFO empty.
- fill  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- led  out  8  level display.

Behaviour:
- Reset (rst=1 at clk edge): pointers 0, fill 0, out_l/out_r 0, overrun/underrun 0, led 0, last-sample register 0.
- Write path:
  - On in_wr with fill<DEPTH: store converted signed IN_W sample s, where s = IN_SIGNED ? in_data : {~in_data[IN_W-1], in_data[IN_W-2:0]}.
  - On in_wr with fill==DEPTH: sample dropped, overrun set.
- Read path:
  - On out_rd with fill>0: pop s.
  - x = s sign-extended and shifted left by (OUT_W-IN_W).
  - y = x << gain, saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Latency: out_l/out_r are valid on the cycle after out_rd and hold until the next pop.
- Routing of y:
  - mode 00: L=R=y.
  - mode 01: L=y, R=0.
  - mode 10: L=0, R=y.
  - mode 11: L=R=0, but the pop still occurs.
  - mode and gain are sampled in the pop cycle only.
- Underrun: out_rd with fill==0 sets underrun, pops nothing, and leaves out_l/out_r unchanged. No fall-through, even if in_wr occurs the same cycle.
- Simultaneous in_wr and out_rd:
  - fill==DEPTH: both succeed, fill unchanged, no overrun.
  - fill==0: write accepted, read underruns, fill becomes 1.
  - otherwise: fill unchanged.
- Pointers wrap modulo DEPTH. fill is an explicit counter, not derived from pointer difference.
- Flags: clr_flags clears both. If a set condition coincides with clr_flags, set wins.
- Reset mid-stream discards FIFO contents. The first post-reset pop returns the first post-reset write.

Optional Feature:
- Macro: LEVEL_METER_EN.
- Defined:
  - Peak register p (IN_W-1 bits), updated per successful pop.
  - a = |s|, with -2^(IN_W-1) saturated to 2^(IN_W-1)-1.
  - If a>p then p=a; else if p>0 then p=p-1.
  - led[i] = (p >= 2^(IN_W-9+i)) for i=0..7, giving a 6 dB-step bar.
  - Mute mode does not stop metering.
- Undefined: led = in_data[IN_W-1:IN_W-8], registered on every in_wr, including dropped writes. No peak logic is instantiated.

Test Plan (IN_W=12, OUT_W=24, DEPTH=16, IN_SIGNED=0, gain=0, mode=00 unless stated):
1. Conversion: write 12'h800, 12'hFFF, 12'h000, then three pops -> out_l=out_r= 24'h000000, 24'h7FF000, 24'h800000 respectively, each valid one cycle after its out_rd.
2. Gain, gain=4:
   - 12'hC00 -> 24'h7FFFFF (saturated).
   - 12'h810 -> 24'h100000.
   - 12'h000 -> 24'h800000 (negative saturation).
3. Full: 17 writes without reads -> fill=16, overrun=1. Sixteen pops return writes 1..16 in order; 17th sample never appears. Write+read same cycle at full -> fill stays 16, overrun unchanged.
4. Empty: pop 12'hA00, then out_rd with FIFO empty -> outputs hold 24'h200000, underrun=1. clr_flags coincident with another empty read -> underrun stays 1. clr_flags alone -> 0.
5. Modes, sample 12'hA00:
   - mode 01 -> L=24'h200000, R=0.
   - mode 10 -> L=0, R=24'h200000.
   - mode 11 -> L=R=0 and fill decrements by 1.
6. LEVEL_METER_EN: pop 12'hFFF -> led=8'hFF. Then pop 12'h800 repeatedly: led[7] clears on pop 1024 of the midscale run (p falls to 1023), and led reaches 8'h00 after 2047 such pops.
